// File: rtl/sram_confreg_pkg.sv
// Shared constants and helpers for the data-SRAM responder: config region base,
// register offsets within it, and reset values.
package sram_confreg_pkg;

    localparam logic [31:0] DEF_CONF_BASE = 32'hbfaf_0000;

    localparam logic [15:0] OFF_CR0    = 16'h8000;
    localparam logic [15:0] OFF_TIMER  = 16'he000;
    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_NUM    = 16'hf010;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;

    localparam int          NUM_CR     = 8;
    localparam logic [15:0] LED_RESET  = 16'hffff;

    // Lanes with be[i] set take new_v, the rest keep old_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_byte_ram.sv
// Word RAM with four byte lanes, per-byte write and synchronous read.
// Read returns the pre-write word when read and write hit the same edge.
module sram_byte_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_confreg.sv
// Data-SRAM responder: local word RAM plus a config region holding scratch
// registers, a free-running timer, LED/number outputs and synchronised switches.
module sram_confreg
    import sram_confreg_pkg::*;
#(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] CONF_BASE = DEF_CONF_BASE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    logic        conf_hit;
    logic [15:0] offset;
    logic        conf_wr;
    logic        hit_cr;
    logic        hit_timer;
    logic        hit_led;
    logic        hit_num;
    logic        hit_switch;
    logic [2:0]  cr_idx;

    logic [31:0] cr_q [NUM_CR];
    logic [31:0] timer_q;
    logic [15:0] led_q;
    logic [31:0] num_q;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;

    logic [31:0] conf_rd_val;
    logic [31:0] conf_q;
    logic        sel_ram_q;
    logic [31:0] ram_q;
    logic [31:0] led_merged;
    logic        unused_bits;

    assign conf_hit   = data_sram_addr[31:16] == CONF_BASE[31:16];
    assign offset     = data_sram_addr[15:0];
    assign conf_wr    = data_sram_en && (data_sram_we != 4'h0) && conf_hit;
    assign cr_idx     = offset[4:2];

    assign hit_cr     = offset[15:5] == OFF_CR0[15:5];
    assign hit_timer  = offset[15:2] == OFF_TIMER[15:2];
    assign hit_led    = offset[15:2] == OFF_LED[15:2];
    assign hit_num    = offset[15:2] == OFF_NUM[15:2];
    assign hit_switch = offset[15:2] == OFF_SWITCH[15:2];

    assign led_merged  = byte_merge({16'h0, led_q}, data_sram_wdata, data_sram_we);
    assign unused_bits = ^{data_sram_addr[1:0], led_merged[31:16]};

    sram_byte_ram #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .en    (data_sram_en && !conf_hit),
        .we    (data_sram_we),
        .addr  (data_sram_addr[RAM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_q)
    );

    always_comb begin
        conf_rd_val = 32'h0;
        if (hit_cr) begin
            conf_rd_val = cr_q[cr_idx];
        end else if (hit_timer) begin
            conf_rd_val = timer_q;
        end else if (hit_led) begin
            conf_rd_val = {16'h0, led_q};
        end else if (hit_num) begin
            conf_rd_val = num_q;
        end else if (hit_switch) begin
            conf_rd_val = {24'h0, sw_sync};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CR; i++) begin
                cr_q[i] <= 32'h0;
            end
            timer_q <= 32'h0;
            led_q   <= LED_RESET;
            num_q   <= 32'h0;
        end else begin
            if (conf_wr && hit_cr) begin
                cr_q[cr_idx] <= byte_merge(cr_q[cr_idx], data_sram_wdata, data_sram_we);
            end
            // A timer write replaces this cycle's increment.
            if (conf_wr && hit_timer) begin
                timer_q <= byte_merge(timer_q, data_sram_wdata, data_sram_we);
            end else begin
                timer_q <= timer_q + 32'd1;
            end
            if (conf_wr && hit_led) begin
                led_q <= led_merged[15:0];
            end
            if (conf_wr && hit_num) begin
                num_q <= byte_merge(num_q, data_sram_wdata, data_sram_we);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= 8'h0;
            sw_sync <= 8'h0;
        end else begin
            sw_meta <= switch_in;
            sw_sync <= sw_meta;
        end
    end

    // Reset selects the config path with conf_q cleared, so rdata reads 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conf_q    <= 32'h0;
            sel_ram_q <= 1'b0;
        end else if (data_sram_en) begin
            conf_q    <= conf_rd_val;
            sel_ram_q <= !conf_hit;
        end
    end

    assign data_sram_rdata = sel_ram_q ? ram_q : conf_q;
    assign led             = led_q;
    assign num_data        = num_q;

endmodule

// File: doc/sram_confreg.md
# sram_confreg

Responder for the CPU's data SRAM port: the slave end of the `data_sram_*` interface that `mycpu_top` drives as initiator. Serves byte-enabled word reads and writes with fixed one-cycle read latency. Decodes each access to either a local word RAM or a configuration-register region holding scratch registers, a free-running timer, LED and numeric-display registers and a synchronised switch input. Sits at SoC level beside the CPU, giving directed tests observable I/O and a timer without an external bus.

## Interface
Parameters:
- `RAM_AW`, 12, word-address width of local RAM (4096 words).
- `CONF_BASE`, 32'hbfaf_0000, base of the 64 KiB config region (compare `addr[31:16]`).

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `resetn`  in  1  **asynchronous, active-low reset**.
- `data_sram_en`  in  1  access request this cycle.
- `data_sram_we`  in  4  byte write enables; 0 = read.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  write data, byte lanes matching `we`.
- `data_sram_rdata`  out  32  read data, valid the cycle after `en`.
- `switch_in`  in  8  raw asynchronous switches.
- `led`  out  16  LED register.
- `num_data`  out  32  numeric-display register.

## Operation
- Decode: `conf_hit = addr[31:16] == CONF_BASE[31:16]`; otherwise local RAM.
- RAM: index `addr[RAM_AW+1:2]`; higher bits ignored, so out-of-range addresses alias (wrap). Per-byte write where `we[i]`. Contents not reset.
- Config offsets (`addr[15:0]`):
  - 0x8000–0x801c: CR0–CR7, R/W, reset 0.
  - 0xe000: TIMER, R/W, reset 0, +1 every cycle (wraps at 2^32).
  - 0xf000: LED, R/W bits [15:0], reset 16'hffff; upper bits read 0.
  - 0xf010: NUM, R/W, reset 0.
  - 0xf020: SWITCH, RO, `{24'b0, sw_sync}`; writes ignored.
  - Any other offset reads 0; writes ignored.
- All config writes honour `we` per byte (merge into the old value).
- Timer write: loaded value is the byte-merged `wdata`, taking the timer's current value in non-written lanes. The write replaces that cycle's increment; counting resumes from the loaded value next cycle.
- Switch: two-flop synchroniser, reset 0.
- `led`, `num_data` drive their registers directly.

## Timing
- Read: `en=1, we=0` at edge N samples the address. `rdata` shows the addressed value from after edge N and holds until the next `en` edge.
- `rdata` is registered; reset value 0. Cycles with `en=0` leave `rdata` unchanged.
- Access with `en=1, we!=0`: the write commits at the edge. `rdata` also updates with the **pre-write** value (read-before-write), for both RAM and config.
- TIMER read returns the value held before the sampling edge, i.e. the count at edge N.
- Back-to-back accesses every cycle are supported; no stall, no backpressure.
- Write followed immediately by a read of the same address returns the new data.
- `resetn` low mid-operation: all registers and `rdata` go to reset values immediately (asynchronous). RAM keeps its contents. The first access after deassertion behaves normally.
- Switch change appears in SWITCH reads no earlier than 2 edges after the input settles.

## Structure
- Shared package/header (`mycpu.h` style defines): CONF_BASE, the config offset constants, reset value of LED.
- One natural sub-module: `sram_byte_ram` (parameterised depth, 4 byte lanes, synchronous read, per-byte write). The decode, register file, timer, synchroniser and read mux live in the top.

## Test plan
- RAM byte write: write 0x11223344 `we=4'hf` @0x100, then `we=4'b0010` with 0xAABBCCDD → read returns 0x1122CC44 one cycle after `en`.
- Read-before-write: RAM @0x0 holds 5; write 9 to @0x0 → `rdata`=5 that cycle; next read → 9.
- Timer: after reset, read TIMER at the 10th edge → 10. Write 0xFFFF_FFFE, then read after 3 edges → 0x0000_0001 (wraps).
- LED/NUM: reset → `led`=16'hffff, `num_data`=0. Write LED 0x0000_00A5 `we=4'h1` → `led`=16'hffa5. Unmapped offset 0xf040 reads 0.
- Switch: set `switch_in`=8'h3c → SWITCH read ≥3 cycles later returns 0x3c; write to SWITCH has no effect.
- Async reset mid-stream: assert `resetn`=0 between edges during back-to-back accesses → `rdata`, CR0–7, TIMER clear with no clock edge. RAM data written before reset still reads back afterwards.
